// File: rtl/perceptron_tables.sv
// State store for the perceptron branch predictor: pending-branch counter, global
// history register with flush rollback, and a signed weight table trained in place.
module perceptron_tables #(
    parameter int ENTRY_W   = 33,
    parameter int GHR_DEPTH = 20,
    parameter int MAX_PUSH  = 4,
    parameter int ROWS      = 228,
    parameter int WEIGHTS   = 8,
    parameter int WEIGHT_W  = 9,
    parameter int PEND_W    = 8,
    localparam int RW = $clog2(ROWS),
    localparam int DW = $clog2(GHR_DEPTH),
    localparam int PW = $clog2(MAX_PUSH + 1)
) (
    input  logic                           fire,
    input  logic                           rst,
    input  logic [PW-1:0]                  i_pushNum,
    input  logic [ENTRY_W*MAX_PUSH-1:0]    i_pushEntries,
    input  logic [PW-1:0]                  i_retireNum,
    input  logic                           i_flush,
    input  logic [DW-1:0]                  i_flushIdx,
    input  logic                           i_trainEn,
    input  logic [RW-1:0]                  i_trainRow,
    input  logic [WEIGHTS-1:0]             i_trainInc,
    input  logic                           i_rdEn,
    input  logic [RW-1:0]                  i_rdRow,
    output logic [ENTRY_W*GHR_DEPTH-1:0]   o_ghr,
    output logic [PEND_W-1:0]              o_pendingB,
    output logic [WEIGHT_W*WEIGHTS-1:0]    o_rdData,
    output logic                           o_rdValid,
    output logic                           o_err
);

    localparam int ROW_W = WEIGHTS * WEIGHT_W;
    localparam int SW    = PEND_W + PW + DW;
    localparam logic [SW-1:0] PEND_MAX = SW'((1 << PEND_W) - 1);
    localparam logic [RW:0]   ROWS_L   = (RW + 1)'(ROWS);
    localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic signed [WEIGHT_W-1:0] W_ONE = WEIGHT_W'(1);

    logic [ENTRY_W-1:0]  ghr_q [GHR_DEPTH];
    logic [ENTRY_W-1:0]  ghr_d [GHR_DEPTH];
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic [ROW_W-1:0]    tbl_q [ROWS];
    logic [ROW_W-1:0]    tbl_d [ROWS];
    logic                vld_p1_q, vld_p1_d;
    logic [RW-1:0]       row_p1_q, row_p1_d;
    logic [WEIGHTS-1:0]  inc_p1_q, inc_p1_d;
    logic [ROW_W-1:0]    data_p1_q, data_p1_d;
    logic [ROW_W-1:0]    rd_data_q, rd_data_d;
    logic                rd_vld_q, rd_vld_d;
    logic                err_q, err_d;
    logic                err_ctrl, err_tbl;
    logic [ROW_W-1:0]    upd_row;
    logic [SW-1:0]       pend_w, push_w, ret_w, sum_w, base_w;

    function automatic logic signed [WEIGHT_W-1:0] sat_step(
        input logic signed [WEIGHT_W-1:0] w,
        input logic                       up
    );
        if (up) sat_step = (w == W_MAX) ? w : w + W_ONE;
        else    sat_step = (w == W_MIN) ? w : w - W_ONE;
    endfunction

    function automatic logic [ROW_W-1:0] train_row(
        input logic [ROW_W-1:0]   row,
        input logic [WEIGHTS-1:0] inc
    );
        logic [ROW_W-1:0] res;
        res = row;
        for (int i = 0; i < WEIGHTS; i++)
            res[i*WEIGHT_W +: WEIGHT_W] = sat_step(row[i*WEIGHT_W +: WEIGHT_W], inc[i]);
        return res;
    endfunction

    // History and pending counter; a flush takes priority over any push.
    always_comb begin
        err_ctrl = 1'b0;
        pend_d   = pend_q;
        pend_w   = SW'(pend_q);
        ret_w    = SW'(i_retireNum);
        push_w   = '0;
        sum_w    = '0;
        base_w   = '0;
        for (int k = 0; k < GHR_DEPTH; k++) ghr_d[k] = ghr_q[k];
        if (i_flush) begin
            if (SW'(i_flushIdx) >= pend_w) begin
                err_ctrl = 1'b1;
            end else begin
                for (int k = 0; k < GHR_DEPTH; k++) begin
                    if (k + int'(i_flushIdx) < GHR_DEPTH) ghr_d[k] = ghr_q[DW'(k + int'(i_flushIdx))];
                    else                                  ghr_d[k] = '0;
                end
                ghr_d[0][0] = ~ghr_d[0][0];
                base_w = pend_w - SW'(i_flushIdx);
                if (ret_w > base_w) begin
                    pend_d   = '0;
                    err_ctrl = 1'b1;
                end else begin
                    pend_d = PEND_W'(base_w - ret_w);
                end
            end
        end else begin
            if (i_pushNum > PW'(MAX_PUSH)) begin
                err_ctrl = 1'b1;
            end else begin
                push_w = SW'(i_pushNum);
                for (int k = 0; k < GHR_DEPTH; k++)
                    if (k >= int'(i_pushNum)) ghr_d[k] = ghr_q[DW'(k - int'(i_pushNum))];
                for (int s = 0; s < MAX_PUSH; s++)
                    if (s < int'(i_pushNum)) ghr_d[s] = i_pushEntries[s*ENTRY_W +: ENTRY_W];
            end
            sum_w = pend_w + push_w;
            if (ret_w > sum_w) begin
                pend_d   = '0;
                err_ctrl = 1'b1;
            end else if (sum_w - ret_w > PEND_MAX) begin
                pend_d   = '1;
                err_ctrl = 1'b1;
            end else begin
                pend_d = PEND_W'(sum_w - ret_w);
            end
        end
    end

    // Stage 1 captures the row (forwarding an in-flight stage-2 result); stage 2 writes it.
    always_comb begin
        upd_row   = train_row(data_p1_q, inc_p1_q);
        err_tbl   = 1'b0;
        vld_p1_d  = 1'b0;
        row_p1_d  = row_p1_q;
        inc_p1_d  = inc_p1_q;
        data_p1_d = data_p1_q;
        if (i_trainEn) begin
            if ({1'b0, i_trainRow} >= ROWS_L) begin
                err_tbl = 1'b1;
            end else begin
                vld_p1_d  = 1'b1;
                row_p1_d  = i_trainRow;
                inc_p1_d  = i_trainInc;
                data_p1_d = (vld_p1_q && row_p1_q == i_trainRow) ? upd_row : tbl_q[i_trainRow];
            end
        end
        rd_vld_d  = i_rdEn;
        rd_data_d = rd_data_q;
        if (i_rdEn) begin
            if ({1'b0, i_rdRow} >= ROWS_L) begin
                rd_data_d = '0;
                err_tbl   = 1'b1;
            end else if (vld_p1_q && row_p1_q == i_rdRow) begin
                rd_data_d = upd_row;
            end else begin
                rd_data_d = tbl_q[i_rdRow];
            end
        end
        for (int r = 0; r < ROWS; r++) tbl_d[r] = tbl_q[r];
        if (vld_p1_q) tbl_d[row_p1_q] = upd_row;
    end

    assign err_d = err_ctrl | err_tbl;

    always_ff @(posedge fire) begin
        if (!rst) begin
            for (int k = 0; k < GHR_DEPTH; k++) ghr_q[k] <= '0;
            for (int r = 0; r < ROWS; r++) tbl_q[r] <= '0;
            pend_q    <= '0;
            vld_p1_q  <= 1'b0;
            row_p1_q  <= '0;
            inc_p1_q  <= '0;
            data_p1_q <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int k = 0; k < GHR_DEPTH; k++) ghr_q[k] <= ghr_d[k];
            for (int r = 0; r < ROWS; r++) tbl_q[r] <= tbl_d[r];
            pend_q    <= pend_d;
            vld_p1_q  <= vld_p1_d;
            row_p1_q  <= row_p1_d;
            inc_p1_q  <= inc_p1_d;
            data_p1_q <= data_p1_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        for (int k = 0; k < GHR_DEPTH; k++) o_ghr[k*ENTRY_W +: ENTRY_W] = ghr_q[k];
    end

    assign o_pendingB = pend_q;
    assign o_rdData   = rd_data_q;
    assign o_rdValid  = rd_vld_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_perceptron_tables.sv
// Directed bench for perceptron_tables: history push/flush, pending counter and weight training.
module tb_perceptron_tables;

    localparam int ENTRY_W   = 33;
    localparam int GHR_DEPTH = 20;
    localparam int MAX_PUSH  = 4;
    localparam int ROWS      = 228;
    localparam int WEIGHTS   = 8;
    localparam int WEIGHT_W  = 9;
    localparam int PEND_W    = 8;
    localparam int RW        = $clog2(ROWS);
    localparam int DW        = $clog2(GHR_DEPTH);
    localparam int PW        = $clog2(MAX_PUSH + 1);
    localparam int ROW_W     = WEIGHTS * WEIGHT_W;

    logic                         fire;
    logic                         rst;
    logic [PW-1:0]                push_num;
    logic [ENTRY_W*MAX_PUSH-1:0]  push_e;
    logic [PW-1:0]                retire;
    logic                         flush;
    logic [DW-1:0]                flush_idx;
    logic                         tr_en;
    logic [RW-1:0]                tr_row;
    logic [WEIGHTS-1:0]           tr_inc;
    logic                         rd_en;
    logic [RW-1:0]                rd_row;
    logic [ENTRY_W*GHR_DEPTH-1:0] o_ghr;
    logic [PEND_W-1:0]            o_pendingB;
    logic [ROW_W-1:0]             o_rdData;
    logic                         o_rdValid;
    logic                         o_err;

    int n_checks = 0;
    int n_errors = 0;

    perceptron_tables #(
        .ENTRY_W(ENTRY_W), .GHR_DEPTH(GHR_DEPTH), .MAX_PUSH(MAX_PUSH), .ROWS(ROWS),
        .WEIGHTS(WEIGHTS), .WEIGHT_W(WEIGHT_W), .PEND_W(PEND_W)
    ) dut (
        .fire(fire), .rst(rst),
        .i_pushNum(push_num), .i_pushEntries(push_e), .i_retireNum(retire),
        .i_flush(flush), .i_flushIdx(flush_idx),
        .i_trainEn(tr_en), .i_trainRow(tr_row), .i_trainInc(tr_inc),
        .i_rdEn(rd_en), .i_rdRow(rd_row),
        .o_ghr(o_ghr), .o_pendingB(o_pendingB), .o_rdData(o_rdData),
        .o_rdValid(o_rdValid), .o_err(o_err)
    );

    initial begin
        fire = 1'b0;
        forever #5 fire = ~fire;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge fire);
        #1;
    endtask

    function automatic logic [ENTRY_W-1:0] ent(input int k);
        return o_ghr[k*ENTRY_W +: ENTRY_W];
    endfunction

    function automatic logic [ROW_W-1:0] fill(input logic [WEIGHT_W-1:0] lo, input logic [WEIGHT_W-1:0] hi);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < WEIGHTS; i++) r[i*WEIGHT_W +: WEIGHT_W] = (i < WEIGHTS/2) ? lo : hi;
        return r;
    endfunction

    function automatic logic [ENTRY_W-1:0] pval(input int c, input int s);
        return ENTRY_W'(c * 16 + s + 1);
    endfunction

    initial begin
        rst = 1'b0; push_num = '0; push_e = '0; retire = '0; flush = 1'b0; flush_idx = '0;
        tr_en = 1'b0; tr_row = '0; tr_inc = '0; rd_en = 1'b0; rd_row = '0;
        step(); step();
        check("rst_pend", 128'(o_pendingB), 0);
        check("rst_ghr", 128'(|o_ghr), 0);
        check("rst_rdvalid", 128'(o_rdValid), 0);
        check("rst_err", 128'(o_err), 0);
        rst = 1'b1;

        push_num = 3;
        push_e = '0;
        push_e[0*ENTRY_W +: ENTRY_W] = 33'h3;
        push_e[1*ENTRY_W +: ENTRY_W] = 33'h2;
        push_e[2*ENTRY_W +: ENTRY_W] = 33'h1;
        step();
        push_num = 0;
        check("push3_e0", 128'(ent(0)), 3);
        check("push3_e1", 128'(ent(1)), 2);
        check("push3_e2", 128'(ent(2)), 1);
        check("push3_e3", 128'(ent(3)), 0);
        check("push3_pend", 128'(o_pendingB), 3);
        check("push3_err", 128'(o_err), 0);

        flush = 1'b1; flush_idx = 1; push_num = 4;
        push_e = {33'h55, 33'h66, 33'h77, 33'h88};
        step();
        flush = 1'b0; push_num = 0;
        check("flush1_e0", 128'(ent(0)), 3);
        check("flush1_e1", 128'(ent(1)), 1);
        check("flush1_e2", 128'(ent(2)), 0);
        check("flush1_pend", 128'(o_pendingB), 2);
        check("flush1_err", 128'(o_err), 0);

        flush = 1'b1; flush_idx = 5;
        step();
        flush = 1'b0;
        check("badflush_e0", 128'(ent(0)), 3);
        check("badflush_e1", 128'(ent(1)), 1);
        check("badflush_pend", 128'(o_pendingB), 2);
        check("badflush_err", 128'(o_err), 1);
        step();
        check("err_clear", 128'(o_err), 0);

        push_num = 2; retire = 1;
        push_e = '0;
        push_e[0*ENTRY_W +: ENTRY_W] = 33'hA;
        push_e[1*ENTRY_W +: ENTRY_W] = 33'hB;
        step();
        push_num = 0; retire = 0;
        check("pr_e0", 128'(ent(0)), 33'hA);
        check("pr_e1", 128'(ent(1)), 33'hB);
        check("pr_e2", 128'(ent(2)), 3);
        check("pr_e3", 128'(ent(3)), 1);
        check("pr_pend", 128'(o_pendingB), 3);

        push_num = 5;
        step();
        push_num = 0;
        check("push5_e0", 128'(ent(0)), 33'hA);
        check("push5_pend", 128'(o_pendingB), 3);
        check("push5_err", 128'(o_err), 1);

        retire = 5;
        step();
        retire = 0;
        check("clip_pend", 128'(o_pendingB), 0);
        check("clip_err", 128'(o_err), 1);

        push_num = 4;
        push_e = {33'h40, 33'h30, 33'h20, 33'h10};
        step();
        push_num = 0;
        flush = 1'b1; flush_idx = 2; retire = 1;
        step();
        flush = 1'b0; retire = 0;
        check("flret_e0", 128'(ent(0)), 33'h31);
        check("flret_e1", 128'(ent(1)), 33'h40);
        check("flret_e2", 128'(ent(2)), 33'hA);
        check("flret_pend", 128'(o_pendingB), 1);
        check("flret_err", 128'(o_err), 0);

        tr_en = 1'b1; tr_row = 7; tr_inc = 8'hFF;
        step(); step(); step();
        tr_en = 1'b0;
        rd_en = 1'b1; rd_row = 7;
        step();
        check("tr7_bypass", 128'(o_rdData), 128'(fill(9'd3, 9'd3)));
        check("tr7_valid", 128'(o_rdValid), 1);
        step();
        check("tr7_read", 128'(o_rdData), 128'(fill(9'd3, 9'd3)));
        rd_en = 1'b0;
        step();
        check("rd_idle_valid", 128'(o_rdValid), 0);
        check("rd_idle_hold", 128'(o_rdData), 128'(fill(9'd3, 9'd3)));

        tr_en = 1'b1; tr_inc = 8'h0F;
        step();
        tr_en = 1'b0;
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("tr7_mixed", 128'(o_rdData), 128'(fill(9'd4, 9'd2)));

        tr_en = 1'b1; tr_row = RW'(228);
        step();
        tr_en = 1'b0;
        check("badtrain_err", 128'(o_err), 1);
        rd_en = 1'b1; rd_row = RW'(228);
        step();
        rd_en = 1'b0;
        check("badrd_data", 128'(o_rdData), 0);
        check("badrd_valid", 128'(o_rdValid), 1);
        check("badrd_err", 128'(o_err), 1);

        tr_en = 1'b1; tr_row = 0; tr_inc = 8'h00;
        repeat (260) step();
        tr_row = 1; tr_inc = 8'hFF;
        repeat (260) step();
        tr_en = 1'b0;
        step();
        rd_en = 1'b1; rd_row = 0;
        step();
        check("sat_neg", 128'(o_rdData), 128'(fill(9'h100, 9'h100)));
        rd_row = 1;
        step();
        rd_en = 1'b0;
        check("sat_pos", 128'(o_rdData), 128'(fill(9'h0FF, 9'h0FF)));

        tr_en = 1'b1; tr_row = 5; tr_inc = 8'hFF;
        step();
        tr_en = 1'b0; rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst2_pend", 128'(o_pendingB), 0);
        check("rst2_ghr", 128'(|o_ghr), 0);
        check("rst2_rddata", 128'(o_rdData), 0);
        rd_en = 1'b1; rd_row = 5;
        step();
        check("rst2_row5", 128'(o_rdData), 0);
        rd_row = 7;
        step();
        rd_en = 1'b0;
        check("rst2_row7", 128'(o_rdData), 0);

        push_num = 4;
        for (int c = 0; c < 70; c++) begin
            for (int s = 0; s < MAX_PUSH; s++) push_e[s*ENTRY_W +: ENTRY_W] = pval(c, s);
            step();
            if (c == 62) begin
                check("psat_252", 128'(o_pendingB), 252);
                check("psat_252_err", 128'(o_err), 0);
            end
            if (c == 63) begin
                check("psat_255", 128'(o_pendingB), 255);
                check("psat_255_err", 128'(o_err), 1);
            end
        end
        push_num = 0;
        check("psat_e0", 128'(ent(0)), 128'(pval(69, 0)));
        check("psat_e1", 128'(ent(1)), 128'(pval(69, 1)));
        check("psat_e4", 128'(ent(4)), 128'(pval(68, 0)));
        check("psat_e19", 128'(ent(19)), 128'(pval(65, 3)));
        check("psat_final", 128'(o_pendingB), 255);
        step();
        check("psat_hold", 128'(o_pendingB), 255);
        check("psat_err_clear", 128'(o_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/perceptron_tables.md
# perceptron_tables

Parametrised state store for the perceptron branch predictor. It holds three things: the pending-branch counter, a multi-entry global history register (GHR) with misprediction rollback, and a signed weight table. The weight table is trained in place by a two-stage read-modify-write pipeline and is read through a registered port. It sits between the fetch-side predictor logic, which pushes history and reads weights, and the branch-resolution logic, which retires branches, flushes on mispredicts and trains weights.

## Interface
Parameters:
- ENTRY_W, 33, width of one GHR entry; bit 0 is the taken/not-taken direction bit.
- GHR_DEPTH, 20, number of GHR entries; entry 0 is the newest.
- MAX_PUSH, 4, maximum number of entries pushed per cycle.
- ROWS, 228, number of weight-table rows.
- WEIGHTS, 8, number of weights per row.
- WEIGHT_W, 9, width of one signed two's-complement weight.
- PEND_W, 8, width of the pending counter.
- Derived: RW = clog2(ROWS), DW = clog2(GHR_DEPTH), PW = clog2(MAX_PUSH+1).

Ports:
- fire  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of fire.
- i_pushNum  in  PW  number of new GHR entries this cycle (0..MAX_PUSH).
- i_pushEntries  in  ENTRY_W*MAX_PUSH  new entries; slot 0 (bits [ENTRY_W-1:0]) is the newest.
- i_retireNum  in  PW  number of branches resolved this cycle.
- i_flush  in  1  misprediction recovery request.
- i_flushIdx  in  DW  age of the mispredicted entry, counted from entry 0.
- i_trainEn  in  1  training request.
- i_trainRow  in  RW  row to train.
- i_trainInc  in  WEIGHTS  per weight: 1 means +1, 0 means -1.
- i_rdEn  in  1  weight read request.
- i_rdRow  in  RW  row to read.
- o_ghr  out  ENTRY_W*GHR_DEPTH  GHR contents; entry k is at bits [k*ENTRY_W +: ENTRY_W].
- o_pendingB  out  PEND_W  pending branch count.
- o_rdData  out  WEIGHT_W*WEIGHTS  registered read data.
- o_rdValid  out  1  o_rdData holds a fresh result.
- o_err  out  1  one-cycle pulse when a request was illegal and dropped.

## Operation
- Reset (rst=0 at an edge) clears the following, overriding every other input: GHR, all weights, o_pendingB, o_rdData, o_rdValid, o_err, and the train stage. All outputs read 0 after reset.
- Push, when i_flush=0:
  - The GHR shifts up by i_pushNum entries and the new entries fill the low slots.
  - Entries shifted beyond GHR_DEPTH-1 are discarded.
  - If i_pushNum > MAX_PUSH, the push is dropped and o_err pulses.
- Flush, when i_flush=1:
  - The GHR shifts down by i_flushIdx entries and zeros fill the top.
  - The direction bit (bit 0) of the new entry 0 is inverted.
  - pending becomes pending - i_flushIdx.
  - Any push in the same cycle is ignored.
  - If i_flushIdx >= pending, the flush is dropped (GHR and pending hold) and o_err pulses.
- Pending counter, when there is no flush:
  - next = pending + pushNum - retireNum.
  - retireNum is clipped so the result is never below 0, and the result saturates at 2^PEND_W-1.
  - A clip or saturation pulses o_err.
  - With a flush, retire is applied after the flush subtraction, with the same clipping.
- Training pipeline:
  - Stage 1 (edge T): the request is latched and row R is captured. If stage 2 is writing R at edge T, the captured value is that stage-2 result (forwarding).
  - Stage 2 (edge T+1): each weight is moved ±1 with saturation to [-2^(WEIGHT_W-1), 2^(WEIGHT_W-1)-1], which is -256..255 by default, and the row is written.
  - Training proceeds regardless of i_flush.
  - i_trainRow >= ROWS drops the request and pulses o_err.
- Read:
  - i_rdEn at edge E loads o_rdData with row i_rdRow as it stands after all writes committed at edge E, so the stage-2 write at E is bypassed into the read.
  - o_rdValid=1 for that cycle and 0 when i_rdEn=0. o_rdData holds its last value while o_rdValid=0.
  - i_rdRow >= ROWS returns zeros with o_rdValid=1 and pulses o_err.

## Timing
- GHR and o_pendingB update at the edge where their inputs are sampled and are visible in the following cycle.
- Read latency is 1 cycle. Reads are fully pipelined, one per cycle.
- Train latency is 2 edges from request to table write. A new request is accepted every cycle, with back-to-back trains of the same row forwarded, so no stalls occur.
- o_err is registered and asserts for exactly the one cycle after the offending edge.
- Reset mid-train discards the in-flight stage-2 write.

## Test plan
- Reset, then push 3 entries 0x1,0x2,0x3 (slot0=0x3) -> next cycle o_ghr entry0=0x3, entry1=0x2, entry2=0x1, o_pendingB=3.
- From pending=3, flush with i_flushIdx=1 -> entry0=0x2 with bit0 inverted (0x3), entry1=0x1, o_pendingB=2. A simultaneous push of 4 entries is ignored.
- Flush with i_flushIdx=5 while pending=2 -> GHR and pending unchanged; o_err=1 for one cycle.
- Train row 7 with i_trainInc=0xFF on 3 consecutive cycles from a zero row -> a read of row 7 two cycles after the last request returns every weight = 3. A read issued in the cycle of the final write also returns 3.
- Train row 0 with i_trainInc=0x00 for 260 cycles -> all weights saturate at -256 (0x100) and never wrap.
- Push 4 per cycle with retire 0 for 70 cycles -> o_pendingB saturates at 255 with an o_err pulse; GHR entry0 holds the newest value and entries beyond 19 are discarded.
